fp_div_sqrt: RTL and testbench

FP_DIV_SQRT -- requirements
Module: fp_div_sqrt

---
 rtl/fp_div_sqrt.sv | 278 +++++++++++++++++++++++++++
 tb/tb_fp_div_sqrt.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fp_div_sqrt.sv
`default_nettype none
//============================================================================
// Module   : fp_div_sqrt
// Desc     : Iterative IEEE-754 divide / square-root unit. One result bit
//            per cycle (restoring radix-2), round-to-nearest-even, subnormal
//            flush-to-zero, speculative flush by sequence number.
// Revision : 1.0 - initial release
//============================================================================
module fp_div_sqrt #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int SQN_W = 7,
  parameter int TAG_W = 7,
  parameter int NM_W  = 5,
  localparam int FW   = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             IN_valid,
  input  logic             IN_op,
  input  logic [FW-1:0]    IN_srcA,
  input  logic [FW-1:0]    IN_srcB,
  input  logic [TAG_W-1:0] IN_tagDst,
  input  logic [NM_W-1:0]  IN_nmDst,
  input  logic [SQN_W-1:0] IN_sqN,
  input  logic [31:0]      IN_pc,
  input  logic             IN_branchTaken,
  input  logic [SQN_W-1:0] IN_branchSqN,
  output logic             OUT_busy,
  output logic             OUT_valid,
  output logic [FW-1:0]    OUT_result,
  output logic [4:0]       OUT_flags,
  output logic [TAG_W-1:0] OUT_tagDst,
  output logic [NM_W-1:0]  OUT_nmDst,
  output logic [SQN_W-1:0] OUT_sqN,
  output logic [31:0]      OUT_pc
);

  // Q result bits: hidden + fraction + guard + round + one spare for the
  // single normalising shift a divide may need.
  localparam int Q  = MAN_W + 4;
  localparam int RW = Q + 3;
  localparam int EW = EXP_W + 3;
  localparam int CW = $clog2(Q) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ITER  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
  localparam logic [CW-1:0]        LAST_CNT = CW'(Q - 1);
  localparam logic [FW-1:0]        QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic [1:0]          r_state, w_next;
  logic [CW-1:0]       r_cnt;
  logic                r_op, r_sign, r_special;
  logic signed [EW-1:0] r_exp;
  logic [RW-1:0]       r_rem;
  logic [MAN_W:0]      r_div;
  logic [Q-1:0]        r_q;
  logic [2*Q-1:0]      r_rad;
  logic [FW-1:0]       r_specRes, r_result;
  logic [4:0]          r_specFlags, r_flags;
  logic [TAG_W-1:0]    r_tagDst;
  logic [NM_W-1:0]     r_nmDst;
  logic [SQN_W-1:0]    r_sqN;
  logic [31:0]         r_pc;

  // Operand decode (subnormals count as zero)
  logic             w_signA, w_signB;
  logic [EXP_W-1:0] w_expA, w_expB;
  logic [MAN_W-1:0] w_fracA, w_fracB;
  logic w_zeroA, w_zeroB, w_infA, w_infB, w_nanA, w_nanB, w_snanA, w_snanB;

  assign {w_signA, w_expA, w_fracA} = IN_srcA;
  assign {w_signB, w_expB, w_fracB} = IN_srcB;
  assign w_zeroA = (w_expA == '0);
  assign w_zeroB = (w_expB == '0);
  assign w_infA  = (&w_expA) && (w_fracA == '0);
  assign w_infB  = (&w_expB) && (w_fracB == '0);
  assign w_nanA  = (&w_expA) && (w_fracA != '0);
  assign w_nanB  = (&w_expB) && (w_fracB != '0);
  assign w_snanA = w_nanA && !w_fracA[MAN_W-1];
  assign w_snanB = w_nanB && !w_fracB[MAN_W-1];

  // Wrap-around sequence comparison: younger than the branch means flushed
  logic [SQN_W-1:0] w_dIn, w_dCur;
  logic w_flushIn, w_flushCur, w_accept;
  assign w_dIn      = IN_sqN - IN_branchSqN;
  assign w_dCur     = r_sqN - IN_branchSqN;
  assign w_flushIn  = IN_branchTaken && !w_dIn[SQN_W-1] && (w_dIn != '0);
  assign w_flushCur = IN_branchTaken && !w_dCur[SQN_W-1] && (w_dCur != '0);
  assign w_accept   = en && IN_valid && !w_flushIn && ((r_state == IDLE) || (r_state == DONE));

  // Initial exponent / radicand; odd unbiased exponent pre-shifts the root input
  logic                 w_odd;
  logic signed [EW-1:0] w_divExp, w_sqExp;
  logic [MAN_W+1:0]     w_sqM;
  assign w_odd    = ~w_expA[0];
  assign w_divExp = EW'(w_expA) - EW'(w_expB) + BIAS;
  assign w_sqExp  = (EW'(w_expA) + BIAS - EW'(w_odd)) >> 1;
  assign w_sqM    = w_odd ? {1'b1, w_fracA, 1'b0} : {1'b0, 1'b1, w_fracA};

  // Special-operand detection resolves the result without iterating
  logic          w_special;
  logic [FW-1:0] w_specRes;
  logic [4:0]    w_specFlags;
  always_comb begin
    w_special   = 1'b0;
    w_specRes   = '0;
    w_specFlags = '0;
    if (!IN_op) begin
      if (w_nanA || w_nanB) begin
        w_special = 1'b1; w_specRes = QNAN; w_specFlags = {w_snanA || w_snanB, 4'b0};
      end else if ((w_zeroA && w_zeroB) || (w_infA && w_infB)) begin
        w_special = 1'b1; w_specRes = QNAN; w_specFlags = 5'b10000;
      end else if (w_infA) begin
        w_special = 1'b1; w_specRes = {w_signA ^ w_signB, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (w_zeroB) begin
        w_special = 1'b1; w_specRes = {w_signA ^ w_signB, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        w_specFlags = 5'b01000;
      end else if (w_zeroA || w_infB) begin
        w_special = 1'b1; w_specRes = {w_signA ^ w_signB, {(FW-1){1'b0}}};
      end
    end else begin
      if (w_nanA) begin
        w_special = 1'b1; w_specRes = QNAN; w_specFlags = {w_snanA, 4'b0};
      end else if (w_zeroA) begin
        w_special = 1'b1; w_specRes = {w_signA, {(FW-1){1'b0}}};
      end else if (w_signA) begin
        w_special = 1'b1; w_specRes = QNAN; w_specFlags = 5'b10000;
      end else if (w_infA) begin
        w_special = 1'b1; w_specRes = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
    end
  end

  // One restoring step: divide subtracts the divisor, sqrt the trial root
  logic [RW-1:0] w_remSh, w_trial, w_iterRem;
  logic [Q-1:0]  w_iterQ;
  assign w_remSh = {r_rem[RW-3:0], r_rad[2*Q-1 -: 2]};
  assign w_trial = RW'({r_q, 2'b01});
  always_comb begin
    w_iterRem = r_rem;
    w_iterQ   = r_q;
    if (!r_op) begin
      if (r_rem >= RW'(r_div)) begin
        w_iterRem = (r_rem - RW'(r_div)) << 1;
        w_iterQ   = {r_q[Q-2:0], 1'b1};
      end else begin
        w_iterRem = r_rem << 1;
        w_iterQ   = {r_q[Q-2:0], 1'b0};
      end
    end else begin
      if (w_remSh >= w_trial) begin
        w_iterRem = w_remSh - w_trial;
        w_iterQ   = {r_q[Q-2:0], 1'b1};
      end else begin
        w_iterRem = w_remSh;
        w_iterQ   = {r_q[Q-2:0], 1'b0};
      end
    end
  end

  // Normalise, round-to-nearest-even, renormalise on carry
  logic                 w_norm, w_g, w_r, w_s, w_up, w_carry, w_nx;
  logic [MAN_W-1:0]     w_frac;
  logic [MAN_W:0]       w_fracSum;
  logic signed [EW-1:0] w_expF;
  assign w_norm    = ~r_q[Q-1];
  assign w_frac    = w_norm ? r_q[Q-3:2] : r_q[Q-2:3];
  assign w_g       = w_norm ? r_q[1] : r_q[2];
  assign w_r       = w_norm ? r_q[0] : r_q[1];
  assign w_s       = (!w_norm && r_q[0]) || (r_rem != '0);
  assign w_up      = w_g && (w_r || w_s || w_frac[0]);
  assign w_fracSum = {1'b0, w_frac} + (MAN_W+1)'(w_up);
  assign w_carry   = w_fracSum[MAN_W];
  assign w_expF    = r_exp - EW'(w_norm) + EW'(w_carry);
  assign w_nx      = w_g || w_r || w_s;

  logic [FW-1:0] w_roundRes;
  logic [4:0]    w_roundFlags;
  // Final pack with overflow to Inf and underflow flushed to signed zero
  always_comb begin
    w_roundRes   = {r_sign, w_expF[EXP_W-1:0], w_fracSum[MAN_W-1:0]};
    w_roundFlags = {4'b0, w_nx};
    if (r_special) begin
      w_roundRes   = r_specRes;
      w_roundFlags = r_specFlags;
    end else if (!w_expF[EW-1] && (w_expF >= EXP_MAX)) begin
      w_roundRes   = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_roundFlags = 5'b00101;
    end else if (w_expF[EW-1] || (w_expF == '0)) begin
      w_roundRes   = {r_sign, {(FW-1){1'b0}}};
      w_roundFlags = 5'b00011;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; an in-flight op that gets flushed drops straight to IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_special ? ROUND : ITER;
      ITER:    if (w_flushCur) w_next = IDLE;
               else if (r_cnt == LAST_CNT) w_next = ROUND;
      ROUND:   w_next = w_flushCur ? IDLE : DONE;
      DONE:    w_next = w_accept ? (w_special ? ROUND : ITER) : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    OUT_busy  = (r_state == ITER) || (r_state == ROUND);
    OUT_valid = (r_state == DONE);
  end

  // Datapath: operand capture, iteration, and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_flags <= '0;
    end else begin
      if (w_accept) begin
        r_op        <= IN_op;
        r_special   <= w_special;
        r_specRes   <= w_specRes;
        r_specFlags <= w_specFlags;
        r_tagDst    <= IN_tagDst;
        r_nmDst     <= IN_nmDst;
        r_sqN       <= IN_sqN;
        r_pc        <= IN_pc;
        r_q         <= '0;
        r_cnt       <= '0;
        if (!IN_op) begin
          r_sign <= w_signA ^ w_signB;
          r_exp  <= w_divExp;
          r_rem  <= RW'({1'b1, w_fracA});
          r_div  <= {1'b1, w_fracB};
          r_rad  <= '0;
        end else begin
          r_sign <= 1'b0;
          r_exp  <= w_sqExp;
          r_rem  <= '0;
          r_div  <= '0;
          r_rad  <= {w_sqM, {(MAN_W+6){1'b0}}};
        end
      end else if (r_state == ITER) begin
        r_rem <= w_iterRem;
        r_q   <= w_iterQ;
        r_rad <= r_rad << 2;
        r_cnt <= r_cnt + 1'b1;
      end
      if ((r_state == ROUND) && !w_flushCur) begin
        r_result <= w_roundRes;
        r_flags  <= w_roundFlags;
      end
    end
  end

  assign OUT_result = r_result;
  assign OUT_flags  = r_flags;
  assign OUT_tagDst = r_tagDst;
  assign OUT_nmDst  = r_nmDst;
  assign OUT_sqN    = r_sqN;
  assign OUT_pc     = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_fp_div_sqrt.sv
`default_nettype none
//============================================================================
// Module   : tb_fp_div_sqrt
// Desc     : Directed bench for fp_div_sqrt with hand-computed vectors.
// Revision : 1.0 - initial release
//============================================================================
module tb_fp_div_sqrt;

  logic        clk;
  logic        rst;
  logic        en;
  logic        IN_valid;
  logic        IN_op;
  logic [31:0] IN_srcA, IN_srcB;
  logic [6:0]  IN_tagDst;
  logic [4:0]  IN_nmDst;
  logic [6:0]  IN_sqN;
  logic [31:0] IN_pc;
  logic        IN_branchTaken;
  logic [6:0]  IN_branchSqN;
  logic        OUT_busy, OUT_valid;
  logic [31:0] OUT_result;
  logic [4:0]  OUT_flags;
  logic [6:0]  OUT_tagDst;
  logic [4:0]  OUT_nmDst;
  logic [6:0]  OUT_sqN;
  logic [31:0] OUT_pc;

  fp_div_sqrt dut (
    .clk(clk), .rst(rst), .en(en),
    .IN_valid(IN_valid), .IN_op(IN_op), .IN_srcA(IN_srcA), .IN_srcB(IN_srcB),
    .IN_tagDst(IN_tagDst), .IN_nmDst(IN_nmDst), .IN_sqN(IN_sqN), .IN_pc(IN_pc),
    .IN_branchTaken(IN_branchTaken), .IN_branchSqN(IN_branchSqN),
    .OUT_busy(OUT_busy), .OUT_valid(OUT_valid), .OUT_result(OUT_result),
    .OUT_flags(OUT_flags), .OUT_tagDst(OUT_tagDst), .OUT_nmDst(OUT_nmDst),
    .OUT_sqN(OUT_sqN), .OUT_pc(OUT_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;

  int          obsLat;
  logic [31:0] obsRes;
  logic [4:0]  obsFlags;
  logic [6:0]  obsSqN, obsTag;
  logic [31:0] obsPc;
  logic        obsBusy1, obsBusyFl;
  logic [6:0]  seqNo;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op and watch up to maxK edges; edge 1 is the accepting edge.
  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic [6:0] sq, input int flushAt, input logic [6:0] brSq,
                       input int rstAt, input int injAt, input int maxK);
    IN_valid  = 1'b1;
    IN_op     = op;
    IN_srcA   = a;
    IN_srcB   = b;
    IN_sqN    = sq;
    IN_tagDst = sq ^ 7'h2A;
    IN_nmDst  = sq[4:0];
    IN_pc     = 32'h1000 + {23'd0, sq, 2'b00};
    obsLat    = 0;
    obsBusy1  = 1'b0;
    obsBusyFl = 1'b1;
    for (int k = 1; k <= maxK && obsLat == 0; k++) begin
      IN_branchTaken = (k == flushAt);
      IN_branchSqN   = brSq;
      if (k == rstAt) rst = 1'b1;
      if (k == injAt) begin
        IN_valid = 1'b1; IN_op = 1'b1; IN_srcA = 32'h41100000; IN_sqN = sq + 7'd1;
      end
      @(posedge clk); #1;
      IN_valid       = 1'b0;
      IN_branchTaken = 1'b0;
      rst            = 1'b0;
      if (k == 1) obsBusy1 = OUT_busy;
      if (flushAt > 0 && k == flushAt + 1) obsBusyFl = OUT_busy;
      if (OUT_valid) begin
        obsLat   = k;
        obsRes   = OUT_result;
        obsFlags = OUT_flags;
        obsSqN   = OUT_sqN;
        obsTag   = OUT_tagDst;
        obsPc    = OUT_pc;
      end
    end
  endtask

  task automatic runOp(input string name, input logic op, input logic [31:0] a,
                       input logic [31:0] b, input int expLat, input logic [31:0] expRes,
                       input logic [4:0] expFlags);
    issue(op, a, b, seqNo, 0, 7'd0, 0, 0, 40);
    checkEq({name, ".lat"}, 64'(obsLat), 64'(expLat));
    checkEq({name, ".res"}, 64'(obsRes), 64'(expRes));
    checkEq({name, ".flags"}, 64'(obsFlags), 64'(expFlags));
    seqNo = seqNo + 7'd1;
    @(posedge clk); #1;
  endtask

  int extra;

  initial begin
    rst = 1'b1; en = 1'b1; IN_valid = 1'b0; IN_op = 1'b0;
    IN_srcA = '0; IN_srcB = '0; IN_tagDst = '0; IN_nmDst = '0; IN_sqN = '0;
    IN_pc = '0; IN_branchTaken = 1'b0; IN_branchSqN = '0; seqNo = 7'd20;
    repeat (3) @(posedge clk);
    #1;
    checkEq("rst.valid", 64'(OUT_valid), 64'd0);
    checkEq("rst.busy", 64'(OUT_busy), 64'd0);
    checkEq("rst.flags", 64'(OUT_flags), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 6.0 / 2.0 with sideband checks
    issue(1'b0, 32'h40C00000, 32'h40000000, 7'd3, 0, 7'd0, 0, 0, 40);
    checkEq("div62.lat", 64'(obsLat), 64'd29);
    checkEq("div62.res", 64'(obsRes), 64'h40400000);
    checkEq("div62.flags", 64'(obsFlags), 64'd0);
    checkEq("div62.sqN", 64'(obsSqN), 64'd3);
    checkEq("div62.tag", 64'(obsTag), 64'h29);
    checkEq("div62.pc", 64'(obsPc), 64'h100C);
    checkEq("div62.busy", 64'(obsBusy1), 64'd1);
    @(posedge clk); #1;

    runOp("sqrt2",   1'b1, 32'h40000000, 32'h0, 29, 32'h3FB504F3, 5'b00001);
    runOp("sqrt9",   1'b1, 32'h41100000, 32'h0, 29, 32'h40400000, 5'b00000);
    runOp("div1by0", 1'b0, 32'h3F800000, 32'h00000000, 2, 32'h7F800000, 5'b01000);
    runOp("sqrtNeg", 1'b1, 32'hBF800000, 32'h0, 2, 32'h7FC00000, 5'b10000);
    runOp("div1by3", 1'b0, 32'h3F800000, 32'h40400000, 29, 32'h3EAAAAAB, 5'b00001);
    runOp("divNeg",  1'b0, 32'hC0C00000, 32'h40000000, 29, 32'hC0400000, 5'b00000);
    runOp("divOvf",  1'b0, 32'h7F000000, 32'h3F000000, 29, 32'h7F800000, 5'b00101);
    runOp("divUnf",  1'b0, 32'h00800000, 32'h40000000, 29, 32'h00000000, 5'b00011);
    runOp("divSub",  1'b0, 32'h3F800000, 32'h00000001, 2, 32'h7F800000, 5'b01000);
    runOp("sNaN",    1'b0, 32'h7F800001, 32'h3F800000, 2, 32'h7FC00000, 5'b10000);
    runOp("qNaN",    1'b0, 32'h7FC00001, 32'h3F800000, 2, 32'h7FC00000, 5'b00000);
    runOp("sqrtM0",  1'b1, 32'h80000000, 32'h0, 2, 32'h80000000, 5'b00000);

    // Flush of the in-flight op: older branch kills it
    issue(1'b0, 32'h40C00000, 32'h40000000, 7'd10, 3, 7'd5, 0, 0, 40);
    checkEq("flush5.lat", 64'(obsLat), 64'd0);
    checkEq("flush5.busy", 64'(obsBusyFl), 64'd0);
    // Younger branch leaves it alone
    issue(1'b0, 32'h40C00000, 32'h40000000, 7'd10, 3, 7'd12, 0, 0, 40);
    checkEq("flush12.lat", 64'(obsLat), 64'd29);
    checkEq("flush12.res", 64'(obsRes), 64'h40400000);
    @(posedge clk); #1;
    // Wrap-around sequence numbers
    issue(1'b0, 32'h40C00000, 32'h40000000, 7'd2, 3, 7'd126, 0, 0, 40);
    checkEq("flushWrap.lat", 64'(obsLat), 64'd0);
    checkEq("flushWrap.busy", 64'(obsBusyFl), 64'd0);

    // Reset at edge 10 cuts the op; the next op goes in right after release
    issue(1'b0, 32'h40C00000, 32'h40000000, 7'd40, 0, 7'd0, 10, 0, 10);
    checkEq("rstCut.lat", 64'(obsLat), 64'd0);
    checkEq("rstCut.busy", 64'(OUT_busy), 64'd0);
    issue(1'b1, 32'h41100000, 32'h0, 7'd41, 0, 7'd0, 0, 0, 40);
    checkEq("rstNext.lat", 64'(obsLat), 64'd29);
    checkEq("rstNext.res", 64'(obsRes), 64'h40400000);
    @(posedge clk); #1;

    // IN_valid while busy is dropped
    issue(1'b0, 32'h40C00000, 32'h40000000, 7'd50, 0, 7'd0, 0, 5, 40);
    checkEq("busyIgn.lat", 64'(obsLat), 64'd29);
    checkEq("busyIgn.res", 64'(obsRes), 64'h40400000);
    checkEq("busyIgn.sqN", 64'(obsSqN), 64'd50);
    extra = 0;
    for (int k = 0; k < 35; k++) begin
      @(posedge clk); #1;
      if (OUT_valid) extra++;
    end
    checkEq("busyIgn.extra", 64'(extra), 64'd0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
